// File: rtl/clock_pkg.sv
// Shared widths and state encoding for the clock's digit entry and split paths.
package clock_pkg;

  localparam int DIGIT_W  = 4;
  localparam int NUMBER_W = 6;
  localparam int BCD_MAX  = 9;

  typedef enum logic [1:0] {
    S_TENS,
    S_ONES,
    S_OUT
  } joiner_state_t;

endpackage

// File: rtl/bcd_pair_to_bin.sv
// Combines a BCD tens/ones pair into binary and checks digit legality and the
// upper bound in one place so both entry stages share the same rule.
module bcd_pair_to_bin
  import clock_pkg::*;
#(
  parameter int MAX_VALUE = 59
) (
  input  logic [DIGIT_W-1:0]  tens_i,
  input  logic [DIGIT_W-1:0]  ones_i,
  output logic [NUMBER_W:0]   sum_o,
  output logic                in_range_o
);

  logic [NUMBER_W:0] tens_w;

  // tens*10 as shift-and-add; an illegal tens digit may wrap, but it is
  // already rejected by the digit check below.
  assign tens_w     = (NUMBER_W+1)'(tens_i);
  assign sum_o      = (tens_w << 3) + (tens_w << 1) + (NUMBER_W+1)'(ones_i);
  assign in_range_o = (tens_i <= DIGIT_W'(BCD_MAX)) &&
                      (ones_i <= DIGIT_W'(BCD_MAX)) &&
                      (sum_o  <= (NUMBER_W+1)'(MAX_VALUE));

endmodule

// File: rtl/digit_joiner.sv
// Two-digit BCD entry: takes a tens then a ones digit, range-checks against
// MAX_VALUE and hands the binary number on over a valid/ready handshake.
module digit_joiner
  import clock_pkg::*;
#(
  parameter int MAX_VALUE      = 59,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                digit_valid_i,
  input  logic [DIGIT_W-1:0]  digit_i,
  output logic                digit_ready_o,
  output logic                number_valid_o,
  input  logic                number_ready_i,
  output logic [NUMBER_W-1:0] number_o,
  output logic [DIGIT_W-1:0]  tens_o,
  output logic                entry_active_o,
  output logic                error_o
);

  joiner_state_t       state_q, state_d;
  logic [DIGIT_W-1:0]  tens_q, tens_d;
  logic [NUMBER_W-1:0] number_q, number_d;
  logic                error_q, error_d;

  logic                accept;
  logic                timeout_hit;
  logic [DIGIT_W-1:0]  chk_tens, chk_ones;
  logic [NUMBER_W:0]   sum;
  logic                in_range;
  logic                sum_unused;

  assign digit_ready_o  = ((state_q == S_TENS) || (state_q == S_ONES)) && !clear_i;
  assign accept         = digit_valid_i && digit_ready_o;
  assign number_valid_o = (state_q == S_OUT);
  assign entry_active_o = (state_q == S_ONES);
  assign number_o       = number_q;
  assign tens_o         = tens_q;
  assign error_o        = error_q;

  // One checker serves both stages: a lone tens digit is checked as tens*10+0.
  assign chk_tens = (state_q == S_ONES) ? tens_q  : digit_i;
  assign chk_ones = (state_q == S_ONES) ? digit_i : '0;

  bcd_pair_to_bin #(
    .MAX_VALUE (MAX_VALUE)
  ) u_check (
    .tens_i     (chk_tens),
    .ones_i     (chk_ones),
    .sum_o      (sum),
    .in_range_o (in_range)
  );

  assign sum_unused = sum[NUMBER_W];

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timer
      localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
      logic [TW-1:0] timer_q, timer_d;

      assign timeout_hit = (state_q == S_ONES) && !accept &&
                           (timer_q == TW'(TIMEOUT_CYCLES - 1));

      // Counts idle cycles spent waiting for the ones digit.
      always_comb begin
        timer_d = timer_q + TW'(1);
        if (clear_i || (state_q != S_ONES) || accept || timeout_hit) begin
          timer_d = '0;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          timer_q <= '0;
        end else begin
          timer_q <= timer_d;
        end
      end
    end else begin : g_no_timer
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // Abort paths (bad ones digit, timeout) drop the held tens digit as well.
  always_comb begin
    state_d  = state_q;
    tens_d   = tens_q;
    number_d = number_q;
    error_d  = 1'b0;
    if (clear_i) begin
      state_d = S_TENS;
      tens_d  = '0;
    end else begin
      unique case (state_q)
        S_TENS: begin
          if (accept) begin
            if (in_range) begin
              tens_d  = digit_i;
              state_d = S_ONES;
            end else begin
              error_d = 1'b1;
            end
          end
        end
        S_ONES: begin
          if (accept) begin
            if (in_range) begin
              number_d = sum[NUMBER_W-1:0];
              state_d  = S_OUT;
            end else begin
              error_d = 1'b1;
              tens_d  = '0;
              state_d = S_TENS;
            end
          end else if (timeout_hit) begin
            error_d = 1'b1;
            tens_d  = '0;
            state_d = S_TENS;
          end
        end
        S_OUT: begin
          if (number_ready_i) begin
            state_d = S_TENS;
          end
        end
        default: state_d = S_TENS;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_TENS;
      tens_q   <= '0;
      number_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tens_q   <= tens_d;
      number_q <= number_d;
      error_q  <= error_d;
    end
  end

endmodule
